sobel_window_gen: RTL and testbench

- Producer side of the sobel 3x3 window interface.
- Accepts a raster-order stream of 1-bit binary pixels and builds the 3x3 neighbourhood with two line buffers and a column shift window.
- Drives s11..s33 to a sobel instance with a valid/ready handshake.
- Emits only fully interior windows: (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_window_gen_line_buffer.sv | 41 ++++
 rtl/sobel_window_gen.sv | 143 ++++++++++++++
 tb/tb_sobel_window_gen.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the sobel 3x3 window producer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sobel_pkg;

    localparam int IMG_W_DEF = 352;
    localparam int IMG_H_DEF = 288;

    // One 3x3 neighbourhood; row 1 is the oldest line, column 1 the oldest pixel.
    typedef struct packed {
        logic s11;
        logic s12;
        logic s13;
        logic s21;
        logic s22;
        logic s23;
        logic s31;
        logic s32;
        logic s33;
    } window_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// 1-bit DEPTH-stage delay line; advances only when en is high.
// Latency: DEPTH enabled cycles from din to dout.
// Backpressure: none; a low en simply freezes the line.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic dout
);

    localparam int PW = cnt_width(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    ptr;

    // The slot about to be overwritten holds the pixel written DEPTH enables ago.
    assign dout = mem[ptr];

    // Storage is deliberately not reset; the first two rows of a frame refill it.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // Circular pointer stepping once per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 windows of a raster 1-bit pixel stream; emits only fully interior windows.
// Latency: 1 cycle from accepting pixel p(r,c) to its window on out_valid.
// Backpressure: skid-free; in_ready = !out_valid || out_ready, input stalls while a window waits.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_pixel,
    output logic out_valid,
    input  logic out_ready,
    output logic s11,
    output logic s12,
    output logic s13,
    output logic s21,
    output logic s22,
    output logic s23,
    output logic s31,
    output logic s32,
    output logic s33,
    output logic out_last,
    output logic frame_done
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          col_wrap;
    logic          row_wrap;
    logic          emit;
    logic          lb1_dout;
    logic          lb2_dout;
    window_t       win;
    window_t       win_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    // Only windows whose three rows and three columns all lie inside the frame.
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    // lb1 yields the pixel from one row up, lb2 the pixel from two rows up.
    line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .din   (in_pixel),
        .dout  (lb1_dout)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .din   (lb1_dout),
        .dout  (lb2_dout)
    );

    // Shift the window left on accept; the new right column is the current column of rows r-2..r.
    always_comb begin
        win_nxt = win;
        if (accept) begin
            win_nxt.s11 = win.s12;
            win_nxt.s12 = win.s13;
            win_nxt.s13 = lb2_dout;
            win_nxt.s21 = win.s22;
            win_nxt.s22 = win.s23;
            win_nxt.s23 = lb1_dout;
            win_nxt.s31 = win.s32;
            win_nxt.s32 = win.s33;
            win_nxt.s33 = in_pixel;
        end
    end

    // Window register; accept only happens when any pending window is being taken, so it stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            win <= '0;
        end else begin
            win <= win_nxt;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Output handshake: a new window replaces a consumed one without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= row_wrap && col_wrap;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // One-cycle pulse after the final pixel of a frame is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && row_wrap && col_wrap;
        end
    end

    assign s11 = win.s11;
    assign s12 = win.s12;
    assign s13 = win.s13;
    assign s21 = win.s21;
    assign s22 = win.s22;
    assign s23 = win.s23;
    assign s31 = win.s31;
    assign s32 = win.s32;
    assign s33 = win.s33;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: 4x4 frames against an image-based window model, plus a 3x3 instance.
// Latency: checks 1-cycle accept-to-window timing.
// Backpressure: exercises held, random and directed out_ready stalls.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic in_valid, in_ready, in_pixel;
    logic out_valid, out_ready, out_last, frame_done;
    logic s11, s12, s13, s21, s22, s23, s31, s32, s33;
    logic [8:0] cur_win;

    logic in3_valid, in3_ready, in3_pixel;
    logic out3_valid, out3_last, frame3_done;
    logic t11, t12, t13, t21, t22, t23, t31, t32, t33;

    assign cur_win = {s11, s12, s13, s21, s22, s23, s31, s32, s33};

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s11 (s11), .s12 (s12), .s13 (s13),
        .s21 (s21), .s22 (s22), .s23 (s23),
        .s31 (s31), .s32 (s32), .s33 (s33),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    sobel_window_gen #(.IMG_W(3), .IMG_H(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in3_valid),
        .in_ready   (in3_ready),
        .in_pixel   (in3_pixel),
        .out_valid  (out3_valid),
        .out_ready  (1'b1),
        .s11 (t11), .s12 (t12), .s13 (t13),
        .s21 (t21), .s22 (t22), .s23 (t23),
        .s31 (t31), .s32 (t32), .s33 (t33),
        .out_last   (out3_last),
        .frame_done (frame3_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the frame image, windows still owed by the DUT, and windows seen.
    logic       img [H][W];
    logic [9:0] exp_q [$];
    logic [9:0] obs_q [$];
    logic [9:0] obs;
    int         frames_exp;
    int         frames_obs;
    logic       rand_rdy = 1'b0;
    logic [8:0] held;
    logic       img3 [9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Neighbourhood of p(r,c) read straight from the image, s11 in the MSB.
    function automatic logic [8:0] ref_window(input int r, input int c);
        logic [8:0] w;
        int k;
        k = 8;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w[k] = img[r - 2 + dr][c - 2 + dc];
                k--;
            end
        end
        return w;
    endfunction

    // Every completed output handshake is compared against the oldest owed window.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            obs = {out_last, cur_win};
            obs_q.push_back(obs);
            if (exp_q.size() == 0) check("spurious_window", exp_q.size(), 1);
            else check("window", obs, exp_q.pop_front());
        end
        if (!reset && frame_done) frames_obs++;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic send_pixel(input logic px, input int gap_max);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = px;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int gap_max);
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            send_pixel(img[r][c], gap_max);
            check("accept_latency", out_valid, (r >= 2 && c >= 2));
            if (r >= 2 && c >= 2) exp_q.push_back({(r == H - 1 && c == W - 1), ref_window(r, c)});
            if (i == W * H - 1) frames_exp++;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic start_phase();
        obs_q.delete();
        frames_obs = 0;
        frames_exp = 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'($urandom);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = 1'b0;
        out_ready = 1'b1;
        in3_valid = 1'b0;
        in3_pixel = 1'b0;
        frames_obs = 0;
        frames_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_window", cur_win, 0);

        // Alternating columns: windows at pixels 10, 11, 14, 15.
        start_phase();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'((r * W + c) % 2);
        send_frame(W * H, 0);
        drain("drain_alt");
        check("alt_count", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("alt_first_window", obs_q[0][8:0], 9'b010_010_010);
            check("alt_last_flags", {obs_q[3][9], obs_q[2][9], obs_q[1][9], obs_q[0][9]}, 4'b1000);
        end
        check("alt_frames", frames_obs, frames_exp);

        // Vertical edge, streamed straight after the previous frame.
        start_phase();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (c >= 2);
        send_frame(W * H, 0);
        drain("drain_edge");
        check("edge_count", obs_q.size(), 4);
        foreach (obs_q[i]) check("edge_right_col", {obs_q[i][6], obs_q[i][3], obs_q[i][0]}, 3'b111);
        check("edge_frames", frames_obs, 1);

        // Consumer stalls for 5 cycles on the first window.
        start_phase();
        fill_random();
        out_ready = 1'b0;
        fork
            send_frame(W * H, 0);
            begin
                int t;
                t = 0;
                while (!out_valid && t < 200) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("stall_seen", out_valid, 1);
                held = cur_win;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold", cur_win, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_count", obs_q.size(), 4);
        check("stall_frames", frames_obs, 1);

        // Random in_valid gaps over two frames.
        start_phase();
        for (int f = 0; f < 2; f++) begin
            fill_random();
            send_frame(W * H, 1);
            drain("drain_gap");
        end
        check("gap_count", obs_q.size(), 8);
        check("gap_frames", frames_obs, 2);

        // Random gaps and random out_ready together.
        start_phase();
        fill_random();
        rand_rdy = 1'b1;
        send_frame(W * H, 2);
        drain("drain_randrdy");
        @(negedge clk);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("randrdy_count", obs_q.size(), 4);
        check("randrdy_frames", frames_obs, 1);

        // Reset at row 2 col 3 with a window pending.
        start_phase();
        fill_random();
        send_frame(2 * W + 4, 0);
        out_ready = 1'b0;
        check("rstmid_pending", out_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        start_phase();
        fill_random();
        send_frame(W * H, 0);
        drain("drain_rstmid");
        check("rstmid_count", obs_q.size(), 4);
        check("rstmid_frames", frames_obs, 1);

        // Minimum 3x3 frame on the second instance.
        for (int i = 0; i < 9; i++) begin
            img3[i] = 1'($urandom);
            in3_valid = 1'b1;
            in3_pixel = img3[i];
            check("min_in_ready", in3_ready, 1);
            @(posedge clk);
            #1;
            check("min_valid", out3_valid, (i == 8));
        end
        in3_valid = 1'b0;
        check("min_last", out3_last, 1);
        check("min_window", {t11, t12, t13, t21, t22, t23, t31, t32, t33},
              {img3[0], img3[1], img3[2], img3[3], img3[4], img3[5], img3[6], img3[7], img3[8]});
        check("min_frame_done", frame3_done, 1);
        @(posedge clk);
        #1;
        check("min_frame_done_pulse", frame3_done, 0);
        check("min_valid_drop", out3_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
